led_pattern_sequencer: RTL and testbench

Controller that sequences the 16-bit board LED bank through selectable animation modes. It replaces the fixed all-on/all-off blinker with a programmable sequencer. It contains its own tick prescaler, a mode register loaded by a strobe from the debounced switch/button logic, and a per-mode pattern state machine. It sits between the user-input block and the top-level led pins.

---
 rtl/led_pattern_sequencer.sv | 148 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: a tick prescaler, a mode register loaded by strobe, and a
// per-mode pattern step engine driving a registered 16-bit LED output.
module led_pattern_sequencer #(
   parameter int TICK_DIV = 50000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        mode_load,
   input  logic [2:0]  mode_in,
   output logic [15:0] led,
   output logic [2:0]  mode_out,
   output logic        tick,
   output logic        wrap
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   localparam logic [2:0] MODE_OFF    = 3'd0;
   localparam logic [2:0] MODE_BLINK  = 3'd1;
   localparam logic [2:0] MODE_CHASE  = 3'd2;
   localparam logic [2:0] MODE_BOUNCE = 3'd3;
   localparam logic [2:0] MODE_COUNT  = 3'd4;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      led_q, led_d;
   logic [2:0]       mode_q, mode_d;
   logic             dir_q, dir_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;

   logic             step;
   logic [2:0]       mode_legal;
   logic [15:0]      seed;
   logic [15:0]      step_led;
   logic             step_dir;
   logic             step_wrap;

   assign step = enable && (cnt_q == CNT_MAX);

   // Codes above COUNT are folded onto OFF so mode_out never shows an illegal code.
   always_comb begin
      mode_legal = (mode_in <= MODE_COUNT) ? mode_in : MODE_OFF;
      case (mode_legal)
         MODE_BLINK:  seed = 16'hFFFF;
         MODE_CHASE:  seed = 16'h0001;
         MODE_BOUNCE: seed = 16'h0001;
         default:     seed = 16'h0000;
      endcase
   end

   always_comb begin
      step_led  = led_q;
      step_dir  = dir_q;
      step_wrap = 1'b0;
      case (mode_q)
         MODE_BLINK: begin
            if (led_q == 16'h0000) begin
               step_led  = 16'hFFFF;
               step_wrap = 1'b1;
            end else begin
               step_led  = 16'h0000;
            end
         end
         MODE_CHASE: begin
            step_led  = {led_q[14:0], led_q[15]};
            step_wrap = (led_q == 16'h8000);
         end
         MODE_BOUNCE: begin
            // Direction flips on the step that lands on an end bit, so each end
            // is shown once per pass and the period is 30 steps.
            if (dir_q == DIR_UP) begin
               step_led = {led_q[14:0], 1'b0};
               if (step_led == 16'h8000) begin
                  step_dir = DIR_DOWN;
               end
            end else begin
               step_led = {1'b0, led_q[15:1]};
               if (step_led == 16'h0001) begin
                  step_dir  = DIR_UP;
                  step_wrap = 1'b1;
               end
            end
         end
         MODE_COUNT: begin
            step_led  = led_q + 16'd1;
            step_wrap = (led_q == 16'hFFFF);
         end
         default: begin
            step_led  = 16'h0000;
         end
      endcase
   end

   // A mode load takes priority over a coincident step, which is then dropped.
   always_comb begin
      cnt_d  = cnt_q;
      led_d  = led_q;
      mode_d = mode_q;
      dir_d  = dir_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (mode_load) begin
         mode_d = mode_legal;
         led_d  = seed;
         cnt_d  = '0;
         dir_d  = DIR_UP;
      end else if (enable) begin
         if (step) begin
            cnt_d  = '0;
            led_d  = step_led;
            dir_d  = step_dir;
            tick_d = 1'b1;
            wrap_d = step_wrap;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         led_q  <= 16'h0000;
         mode_q <= MODE_OFF;
         dir_q  <= DIR_UP;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         led_q  <= led_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign led      = led_q;
   assign mode_out = mode_q;
   assign tick     = tick_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: a TICK_DIV=4 instance for the
// vector table and corner sequences, and a TICK_DIV=1 instance for full COUNT wrap.
module tb_led_pattern_sequencer;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        mode_load;
   logic [2:0]  mode_in;
   logic [15:0] led;
   logic [2:0]  mode_out;
   logic        tick;
   logic        wrap;

   logic        enable2;
   logic        mode_load2;
   logic [2:0]  mode_in2;
   logic [15:0] led2;
   logic [2:0]  mode_out2;
   logic        tick2;
   logic        wrap2;

   int n_checks;
   int n_fail;

   led_pattern_sequencer #(.TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode_load(mode_load),
      .mode_in(mode_in), .led(led), .mode_out(mode_out), .tick(tick), .wrap(wrap)
   );

   led_pattern_sequencer #(.TICK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable2), .mode_load(mode_load2),
      .mode_in(mode_in2), .led(led2), .mode_out(mode_out2), .tick(tick2), .wrap(wrap2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        ml;
      logic [2:0]  mi;
      logic [15:0] led;
      logic [2:0]  mode;
      logic        tick;
      logic        wrap;
   } vec_t;

   vec_t vecs[35];

   function automatic vec_t mk(logic en, logic ml, logic [2:0] mi, logic [15:0] l,
                               logic [2:0] m, logic t, logic w);
      vec_t v;
      v.en = en; v.ml = ml; v.mi = mi; v.led = l; v.mode = m; v.tick = t; v.wrap = w;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string name, input logic [15:0] l, input logic [2:0] m,
                             input logic t, input logic w);
      check({name, ".led"}, 32'(led), 32'(l));
      check({name, ".mode"}, 32'(mode_out), 32'(m));
      check({name, ".tick"}, 32'(tick), 32'(t));
      check({name, ".wrap"}, 32'(wrap), 32'(w));
   endtask

   task automatic idle_cycles(input int n, input logic [15:0] l, input string name);
      for (int i = 0; i < n; i++) begin
         cyc();
         check({name, ".led_hold"}, 32'(led), 32'(l));
         check({name, ".no_tick"}, 32'(tick), 32'h0);
      end
   endtask

   initial begin
      logic [15:0] exp_led;
      int          bad;
      int          wraps;

      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      mode_load  = 1'b0;
      mode_in    = 3'd0;
      enable2    = 1'b0;
      mode_load2 = 1'b0;
      mode_in2   = 3'd0;

      vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[1]  = mk(1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[2]  = mk(1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[3]  = mk(1, 0, 0, 16'h0000, 0, 1, 0);
      vecs[4]  = mk(1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[5]  = mk(1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[6]  = mk(1, 0, 0, 16'h0000, 0, 0, 0);
      vecs[7]  = mk(1, 0, 0, 16'h0000, 0, 1, 0);
      vecs[8]  = mk(1, 1, 2, 16'h0001, 2, 0, 0);
      vecs[9]  = mk(1, 0, 0, 16'h0001, 2, 0, 0);
      vecs[10] = mk(1, 0, 0, 16'h0001, 2, 0, 0);
      vecs[11] = mk(1, 0, 0, 16'h0001, 2, 0, 0);
      vecs[12] = mk(1, 0, 0, 16'h0002, 2, 1, 0);
      vecs[13] = mk(1, 0, 0, 16'h0002, 2, 0, 0);
      vecs[14] = mk(0, 0, 0, 16'h0002, 2, 0, 0);
      vecs[15] = mk(1, 0, 0, 16'h0002, 2, 0, 0);
      vecs[16] = mk(1, 0, 0, 16'h0002, 2, 0, 0);
      vecs[17] = mk(1, 0, 0, 16'h0004, 2, 1, 0);
      vecs[18] = mk(1, 1, 1, 16'hFFFF, 1, 0, 0);
      vecs[19] = mk(1, 0, 0, 16'hFFFF, 1, 0, 0);
      vecs[20] = mk(1, 0, 0, 16'hFFFF, 1, 0, 0);
      vecs[21] = mk(1, 0, 0, 16'hFFFF, 1, 0, 0);
      vecs[22] = mk(1, 0, 0, 16'h0000, 1, 1, 0);
      vecs[23] = mk(1, 0, 0, 16'h0000, 1, 0, 0);
      vecs[24] = mk(1, 0, 0, 16'h0000, 1, 0, 0);
      vecs[25] = mk(1, 0, 0, 16'h0000, 1, 0, 0);
      vecs[26] = mk(1, 0, 0, 16'hFFFF, 1, 1, 1);
      vecs[27] = mk(0, 1, 5, 16'h0000, 0, 0, 0);
      vecs[28] = mk(0, 0, 0, 16'h0000, 0, 0, 0);
      vecs[29] = mk(0, 1, 4, 16'h0000, 4, 0, 0);
      vecs[30] = mk(0, 0, 0, 16'h0000, 4, 0, 0);
      vecs[31] = mk(1, 0, 0, 16'h0000, 4, 0, 0);
      vecs[32] = mk(1, 0, 0, 16'h0000, 4, 0, 0);
      vecs[33] = mk(1, 0, 0, 16'h0000, 4, 0, 0);
      vecs[34] = mk(1, 0, 0, 16'h0001, 4, 1, 0);

      // Reset
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cyc();
      check_outs("post_reset_idle", 16'h0000, 3'd0, 1'b0, 1'b0);

      // Vector table
      for (int i = 0; i < 35; i++) begin
         enable    = vecs[i].en;
         mode_load = vecs[i].ml;
         mode_in   = vecs[i].mi;
         cyc();
         check_outs($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode, vecs[i].tick, vecs[i].wrap);
      end
      mode_load = 1'b0;
      mode_in   = 3'd0;

      // CHASE full period
      enable = 1'b1; mode_load = 1'b1; mode_in = 3'd2;
      cyc();
      mode_load = 1'b0;
      check_outs("chase_seed", 16'h0001, 3'd2, 1'b0, 1'b0);
      exp_led = 16'h0001;
      for (int k = 1; k <= 16; k++) begin
         for (int j = 0; j < 3; j++) begin
            cyc();
            check("chase_gap_tick", 32'(tick), 32'h0);
            check("chase_gap_wrap", 32'(wrap), 32'h0);
         end
         cyc();
         exp_led = {exp_led[14:0], exp_led[15]};
         check("chase_tick", 32'(tick), 32'h1);
         check("chase_led", 32'(led), 32'(exp_led));
         check("chase_wrap", 32'(wrap), (k == 16) ? 32'h1 : 32'h0);
      end

      // BOUNCE 31 steps
      mode_load = 1'b1; mode_in = 3'd3;
      cyc();
      mode_load = 1'b0;
      check_outs("bounce_seed", 16'h0001, 3'd3, 1'b0, 1'b0);
      for (int k = 1; k <= 31; k++) begin
         for (int j = 0; j < 3; j++) begin
            cyc();
            check("bounce_gap_tick", 32'(tick), 32'h0);
         end
         cyc();
         if (k <= 15)      exp_led = 16'(32'h1 << k);
         else if (k <= 30) exp_led = 16'(32'h1 << (30 - k));
         else              exp_led = 16'h0002;
         check("bounce_tick", 32'(tick), 32'h1);
         check("bounce_led", 32'(led), 32'(exp_led));
         check("bounce_wrap", 32'(wrap), (k == 30) ? 32'h1 : 32'h0);
      end

      // Freeze mid-count at 0008
      mode_load = 1'b1; mode_in = 3'd2;
      cyc();
      mode_load = 1'b0;
      repeat (12) cyc();
      check_outs("freeze_pre", 16'h0008, 3'd2, 1'b1, 1'b0);
      idle_cycles(2, 16'h0008, "freeze_run");
      enable = 1'b0;
      idle_cycles(10, 16'h0008, "freeze_off");
      enable = 1'b1;
      cyc();
      check_outs("resume_1", 16'h0008, 3'd2, 1'b0, 1'b0);
      cyc();
      check_outs("resume_2", 16'h0010, 3'd2, 1'b1, 1'b0);

      // Load coincident with step: load wins, step dropped
      idle_cycles(3, 16'h0010, "collide_run");
      mode_load = 1'b1; mode_in = 3'd7;
      cyc();
      mode_load = 1'b0;
      check_outs("collide", 16'h0000, 3'd0, 1'b0, 1'b0);
      idle_cycles(3, 16'h0000, "collide_after");
      cyc();
      check_outs("collide_restart", 16'h0000, 3'd0, 1'b1, 1'b0);

      // Asynchronous reset mid-pattern
      mode_load = 1'b1; mode_in = 3'd3;
      cyc();
      mode_load = 1'b0;
      repeat (9) cyc();
      check_outs("pre_reset", 16'h0004, 3'd3, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check_outs("after_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
      enable = 1'b0;

      // TICK_DIV=1: COUNT full wrap
      enable2 = 1'b1; mode_load2 = 1'b1; mode_in2 = 3'd4;
      cyc();
      mode_load2 = 1'b0;
      check("count_seed_led", 32'(led2), 32'h0);
      check("count_seed_mode", 32'(mode_out2), 32'h4);
      check("count_seed_tick", 32'(tick2), 32'h0);
      bad   = 0;
      wraps = 0;
      for (int n = 1; n <= 65536; n++) begin
         cyc();
         if (led2 !== 16'(n)) bad++;
         if (tick2 !== 1'b1) bad++;
         if (wrap2 === 1'b1) wraps++;
         if (n == 65535) begin
            check("count_ffff_led", 32'(led2), 32'hFFFF);
            check("count_ffff_wrap", 32'(wrap2), 32'h0);
         end
         if (n == 65536) begin
            check("count_wrap_led", 32'(led2), 32'h0);
            check("count_wrap_wrap", 32'(wrap2), 32'h1);
         end
      end
      check("count_sequence_errors", 32'(bad), 32'h0);
      check("count_wrap_total", 32'(wraps), 32'h1);

      // TICK_DIV=1: BLINK
      mode_load2 = 1'b1; mode_in2 = 3'd1;
      cyc();
      mode_load2 = 1'b0;
      check("blink_seed", 32'(led2), 32'hFFFF);
      check("blink_seed_tick", 32'(tick2), 32'h0);
      cyc();
      check("blink_s1_led", 32'(led2), 32'h0000);
      check("blink_s1_wrap", 32'(wrap2), 32'h0);
      cyc();
      check("blink_s2_led", 32'(led2), 32'hFFFF);
      check("blink_s2_wrap", 32'(wrap2), 32'h1);
      cyc();
      check("blink_s3_led", 32'(led2), 32'h0000);
      check("blink_s3_wrap", 32'(wrap2), 32'h0);
      enable2 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
